mmio_peripherals: RTL

Memory-mapped peripheral block on the CPU's device bus, alongside data memory. It decodes the CPU's bus address and read/write strobes for the 0x4000_0000 region, and holds a reloadable timer with an interrupt, an LED register, a 7-segment digit register and a free-running SysTick counter. Read data returns to the CPU's MEM stage in the same cycle as the access.

---
 rtl/mmio_peripherals_pkg.sv | 49 ++++
 rtl/mmio_timer.sv | 73 +++++++
 rtl/mmio_peripherals.sv | 80 ++++++++
 3 files changed

// File: rtl/mmio_peripherals_pkg.sv
// ============================================================================
// mmio_peripherals_pkg: register map, TCON bit indices and decode helper
// Rev 1.0
// ============================================================================
`default_nettype none

package mmio_peripherals_pkg;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h4000_0000;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LEDS    = 5'h0C;
  localparam logic [4:0] OFF_DIGITS  = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [2:0] {
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LEDS,
    SEL_DIGITS,
    SEL_SYSTICK,
    SEL_NONE
  } reg_sel_e;

  // Byte lane bits are ignored; offsets 0x18-0x1C fall through to SEL_NONE.
  function automatic reg_sel_e decode_offset(input logic [4:0] off);
    reg_sel_e sel;
    case ({off[4:2], 2'b00})
      OFF_TH:      sel = SEL_TH;
      OFF_TL:      sel = SEL_TL;
      OFF_TCON:    sel = SEL_TCON;
      OFF_LEDS:    sel = SEL_LEDS;
      OFF_DIGITS:  sel = SEL_DIGITS;
      OFF_SYSTICK: sel = SEL_SYSTICK;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// mmio_timer: reloadable 32-bit timer with TH/TL/TCON and interrupt status
// Optional: TIMER_IRQ_EN implements TCON[2:1] and irq. Rev 1.0
// ============================================================================
`default_nettype none

module mmio_timer
  import mmio_peripherals_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic tcon_en;
  logic tcon_ie;
  logic tcon_is;
  logic overflow;

  assign overflow = tcon_en && (tl == 32'hFFFF_FFFF);
  assign tcon     = {tcon_is, tcon_ie, tcon_en};

  always_ff @(posedge clk) begin
    if (!reset) begin
      th      <= 32'h0;
      tl      <= 32'h0;
      tcon_en <= 1'b0;
    end else begin
      if (th_we)
        th <= wdata;
      // A CPU write to TL takes priority over both reload and increment.
      if (tl_we)
        tl <= wdata;
      else if (tcon_en)
        tl <= overflow ? th : tl + 32'd1;
      if (tcon_we)
        tcon_en <= wdata[TCON_EN];
    end
  end

`ifdef TIMER_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcon_ie <= 1'b0;
      tcon_is <= 1'b0;
    end else begin
      if (tcon_we)
        tcon_ie <= wdata[TCON_IE];
      // Overflow beats a simultaneous software clear of the status bit.
      if (overflow && tcon_ie)
        tcon_is <= 1'b1;
      else if (tcon_we)
        tcon_is <= wdata[TCON_IS];
    end
  end

  assign irq = tcon_is;
`else
  assign tcon_ie = 1'b0;
  assign tcon_is = 1'b0;
  assign irq     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mmio_peripherals.sv
// ============================================================================
// mmio_peripherals: device-bus decode, read mux, timer, LEDs, digits, SysTick
// Optional: TIMER_IRQ_EN enables timer interrupt bits. Rev 1.0
// ============================================================================
`default_nettype none

module mmio_peripherals
  import mmio_peripherals_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
  parameter int          LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Device_Read,
  input  logic             Device_Write,
  input  logic [31:0]      MemBus_Address,
  input  logic [31:0]      MemBus_Write_Data,
  output logic [31:0]      Device_Read_Data,
  output logic             irq,
  output logic [LED_W-1:0] leds,
  output logic [11:0]      digits
);

  logic        region_hit;
  reg_sel_e    sel;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  assign region_hit = (MemBus_Address[31:5] == ADDR_BASE[31:5]);
  assign sel        = region_hit ? decode_offset(MemBus_Address[4:0]) : SEL_NONE;

  mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (Device_Write && (sel == SEL_TH)),
    .tl_we   (Device_Write && (sel == SEL_TL)),
    .tcon_we (Device_Write && (sel == SEL_TCON)),
    .wdata   (MemBus_Write_Data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (irq)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      leds    <= '0;
      digits  <= 12'h0;
      systick <= 32'h0;
    end else begin
      systick <= systick + 32'd1;
      if (Device_Write && (sel == SEL_LEDS))
        leds <= MemBus_Write_Data[LED_W-1:0];
      if (Device_Write && (sel == SEL_DIGITS))
        digits <= MemBus_Write_Data[11:0];
    end
  end

  // Combinational so the MEM stage sees data in the access cycle (pre-write value).
  always_comb begin
    Device_Read_Data = 32'h0;
    if (Device_Read) begin
      case (sel)
        SEL_TH:      Device_Read_Data = th;
        SEL_TL:      Device_Read_Data = tl;
        SEL_TCON:    Device_Read_Data[2:0] = tcon;
        SEL_LEDS:    Device_Read_Data[LED_W-1:0] = leds;
        SEL_DIGITS:  Device_Read_Data[11:0] = digits;
        SEL_SYSTICK: Device_Read_Data = systick;
        default:     Device_Read_Data = 32'h0;
      endcase
    end
  end

endmodule

`default_nettype wire
